// File: rtl/tiny16_bus_arbiter.sv
// tiny16_bus_arbiter: two-requester (CPU m0, DMA m1) arbiter onto one shared
// 16-bit memory port. One access at a time: IDLE -> ACCESS -> DONE -> IDLE.
// An access ends on mem_ready or after TIMEOUT wait cycles, which aborts it
// with an error flag and all-ones read data.
module tiny16_bus_arbiter #(
  parameter int unsigned ROUND_ROBIN = 1,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic        clk,
  input  logic        reset,
  // requester 0 (CPU)
  input  logic        m0_rd_n,
  input  logic        m0_wr_n,
  input  logic [15:0] m0_address,
  input  logic [15:0] m0_wdata,
  output logic [15:0] m0_rdata,
  output logic        m0_ready,
  output logic        m0_error,
  // requester 1 (DMA)
  input  logic        m1_rd_n,
  input  logic        m1_wr_n,
  input  logic [15:0] m1_address,
  input  logic [15:0] m1_wdata,
  output logic [15:0] m1_rdata,
  output logic        m1_ready,
  output logic        m1_error,
  // shared memory
  output logic        mem_rd_n,
  output logic        mem_wr_n,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic [1:0]  grant
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_t;

  state_t          state_q;
  logic            owner_q;      // 0 = m0, 1 = m1
  logic            write_q;
  logic            last_q;       // requester granted most recently
  logic [CW-1:0]   cnt_q;
  logic [1:0]      grant_q;
  logic            mem_rd_n_q;
  logic            mem_wr_n_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   m0_rdata_q;
  logic [DW-1:0]   m1_rdata_q;
  logic            m0_ready_q;
  logic            m0_error_q;
  logic            m1_ready_q;
  logic            m1_error_q;

  logic            req0_c;
  logic            req1_c;
  logic            any_req_c;
  logic            win_d;
  logic            write_d;
  logic [AW-1:0]   addr_d;
  logic [DW-1:0]   wdata_d;
  logic            timeout_c;

  // Request decode and winner selection for the next grant.
  always_comb begin
    req0_c    = ~m0_rd_n | ~m0_wr_n;
    req1_c    = ~m1_rd_n | ~m1_wr_n;
    any_req_c = req0_c | req1_c;
    win_d     = 1'b0;
    if (req0_c && req1_c) begin
      win_d = (ROUND_ROBIN != 0) ? ~last_q : 1'b0;
    end else if (req1_c) begin
      win_d = 1'b1;
    end
    // both strobes low counts as a write
    write_d   = win_d ? ~m1_wr_n : ~m0_wr_n;
    addr_d    = win_d ? m1_address : m0_address;
    wdata_d   = win_d ? m1_wdata : m0_wdata;
    timeout_c = (cnt_q == TO_LAST);
  end

  // Arbitration FSM with registered memory-side and requester-side outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      write_q    <= 1'b0;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      grant_q    <= 2'b00;
      mem_rd_n_q <= 1'b1;
      mem_wr_n_q <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      m0_ready_q <= 1'b0;
      m0_error_q <= 1'b0;
      m1_ready_q <= 1'b0;
      m1_error_q <= 1'b0;
    end else begin
      m0_ready_q <= 1'b0;
      m0_error_q <= 1'b0;
      m1_ready_q <= 1'b0;
      m1_error_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (any_req_c) begin
            owner_q    <= win_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            grant_q    <= win_d ? 2'b10 : 2'b01;
            cnt_q      <= '0;
            mem_rd_n_q <= write_d;
            mem_wr_n_q <= ~write_d;
            state_q    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (mem_ready || timeout_c) begin
            mem_rd_n_q <= 1'b1;
            mem_wr_n_q <= 1'b1;
            state_q    <= ST_DONE;
            if (owner_q) begin
              m1_ready_q <= 1'b1;
              m1_error_q <= ~mem_ready;
              if (!mem_ready) begin
                m1_rdata_q <= 16'hFFFF;
              end else if (!write_q) begin
                m1_rdata_q <= mem_rdata;
              end
            end else begin
              m0_ready_q <= 1'b1;
              m0_error_q <= ~mem_ready;
              if (!mem_ready) begin
                m0_rdata_q <= 16'hFFFF;
              end else if (!write_q) begin
                m0_rdata_q <= mem_rdata;
              end
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DONE: begin
          grant_q <= 2'b00;
          last_q  <= owner_q;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign m0_rdata    = m0_rdata_q;
  assign m0_ready    = m0_ready_q;
  assign m0_error    = m0_error_q;
  assign m1_rdata    = m1_rdata_q;
  assign m1_ready    = m1_ready_q;
  assign m1_error    = m1_error_q;
  assign mem_rd_n    = mem_rd_n_q;
  assign mem_wr_n    = mem_wr_n_q;
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;
  assign grant       = grant_q;

endmodule

// File: tb/tb_tiny16_bus_arbiter.sv
// Directed bench for tiny16_bus_arbiter: a round-robin instance and a
// fixed-priority instance share all inputs.
module tb_tiny16_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_rd_n, m0_wr_n, m1_rd_n, m1_wr_n;
  logic [15:0] m0_address, m0_wdata, m1_address, m1_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  logic [15:0] m0_rdata, m1_rdata, mem_address, mem_wdata;
  logic        m0_ready, m0_error, m1_ready, m1_error, mem_rd_n, mem_wr_n;
  logic [1:0]  grant;

  logic [15:0] f_m0_rdata, f_m1_rdata, f_mem_address, f_mem_wdata;
  logic        f_m0_ready, f_m0_error, f_m1_ready, f_m1_error, f_mem_rd_n, f_mem_wr_n;
  logic [1:0]  f_grant;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  tiny16_bus_arbiter #(.ROUND_ROBIN(1), .TIMEOUT(15)) u_dut (
    .clk(clk), .reset(reset),
    .m0_rd_n(m0_rd_n), .m0_wr_n(m0_wr_n), .m0_address(m0_address), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_error(m0_error),
    .m1_rd_n(m1_rd_n), .m1_wr_n(m1_wr_n), .m1_address(m1_address), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_error(m1_error),
    .mem_rd_n(mem_rd_n), .mem_wr_n(mem_wr_n), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .grant(grant)
  );

  tiny16_bus_arbiter #(.ROUND_ROBIN(0), .TIMEOUT(15)) u_dut_fp (
    .clk(clk), .reset(reset),
    .m0_rd_n(m0_rd_n), .m0_wr_n(m0_wr_n), .m0_address(m0_address), .m0_wdata(m0_wdata),
    .m0_rdata(f_m0_rdata), .m0_ready(f_m0_ready), .m0_error(f_m0_error),
    .m1_rd_n(m1_rd_n), .m1_wr_n(m1_wr_n), .m1_address(m1_address), .m1_wdata(m1_wdata),
    .m1_rdata(f_m1_rdata), .m1_ready(f_m1_ready), .m1_error(f_m1_error),
    .mem_rd_n(f_mem_rd_n), .mem_wr_n(f_mem_wr_n), .mem_address(f_mem_address),
    .mem_wdata(f_mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .grant(f_grant)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_rr [4];

  initial begin
    exp_rr[0] = 2'b01; exp_rr[1] = 2'b10; exp_rr[2] = 2'b01; exp_rr[3] = 2'b10;
    reset = 1'b0;
    m0_rd_n = 1'b1; m0_wr_n = 1'b1; m1_rd_n = 1'b1; m1_wr_n = 1'b1;
    m0_address = '0; m0_wdata = '0; m1_address = '0; m1_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;

    // reset state
    tick(); tick();
    check("rst_rd_n", 32'(mem_rd_n), 32'h1);
    check("rst_wr_n", 32'(mem_wr_n), 32'h1);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_ready", 32'({m0_ready, m0_error, m1_ready, m1_error}), 32'h0);
    check("rst_rdata", 32'({m0_rdata, m1_rdata}), 32'h0);
    check("rst_addr", 32'({mem_address, mem_wdata}), 32'h0);
    reset = 1'b1;
    tick();

    // m0 read, zero-wait memory; strobe dropped during ACCESS
    m0_rd_n = 1'b0; m0_address = 16'h0100; mem_ready = 1'b1; mem_rdata = 16'h1234;
    tick();
    check("rd_grant", 32'(grant), 32'h1);
    check("rd_strobes", 32'({mem_rd_n, mem_wr_n}), 32'b01);
    check("rd_addr", 32'(mem_address), 32'h0100);
    check("rd_early_ready", 32'(m0_ready), 32'h0);
    m0_rd_n = 1'b1;
    tick();
    check("rd_ready", 32'({m0_ready, m0_error, m1_ready}), 32'b100);
    check("rd_rdata", 32'(m0_rdata), 32'h1234);
    check("rd_done_strobes", 32'({mem_rd_n, mem_wr_n}), 32'b11);
    tick();
    check("rd_idle_grant", 32'(grant), 32'h0);
    check("rd_ready_once", 32'(m0_ready), 32'h0);
    check("rd_rdata_hold", 32'(m0_rdata), 32'h1234);

    // m1 write with 3 wait cycles; read data must not change
    m1_wr_n = 1'b0; m1_address = 16'h8000; m1_wdata = 16'hBEEF;
    mem_ready = 1'b0; mem_rdata = 16'h5555;
    tick();
    check("wr_grant", 32'(grant), 32'h2);
    m1_wr_n = 1'b1; m1_wdata = 16'h0000; m1_address = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      check("wr_strobe", 32'({mem_rd_n, mem_wr_n}), 32'b10);
      check("wr_bus", 32'({mem_address, mem_wdata}), 32'h8000BEEF);
      check("wr_no_ready", 32'(m1_ready), 32'h0);
      mem_ready = (i == 3);
      tick();
    end
    check("wr_ready", 32'({m1_ready, m1_error, m0_ready}), 32'b100);
    check("wr_no_fwd", 32'(m1_rdata), 32'h0);
    check("wr_done_strobe", 32'(mem_wr_n), 32'h1);
    mem_ready = 1'b0;
    tick();
    check("wr_ready_once", 32'(m1_ready), 32'h0);

    // both request continuously, zero-wait memory
    m0_rd_n = 1'b0; m1_rd_n = 1'b0; m0_address = 16'h0010; m1_address = 16'h0020;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_grant", 32'(grant), 32'(exp_rr[i]));
      check("fp_grant", 32'(f_grant), 32'h1);
      check("rr_addr", 32'(mem_address), (exp_rr[i] == 2'b01) ? 32'h10 : 32'h20);
      tick();
      check("rr_ready", 32'({m0_ready, m1_ready}), (exp_rr[i] == 2'b01) ? 32'b10 : 32'b01);
      tick();
    end
    m0_rd_n = 1'b1; m1_rd_n = 1'b1; mem_ready = 1'b0;
    tick(); tick(); tick();

    // m0 read times out after 15 ACCESS cycles
    m0_rd_n = 1'b0; m0_address = 16'h0200; mem_rdata = 16'h1111;
    tick();
    m0_rd_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      check("to_strobe", 32'(mem_rd_n), 32'h0);
      check("to_no_ready", 32'(m0_ready), 32'h0);
      tick();
    end
    check("to_ready", 32'({m0_ready, m0_error}), 32'b11);
    check("to_rdata", 32'(m0_rdata), 32'hFFFF);
    check("to_strobe_off", 32'(mem_rd_n), 32'h1);
    tick();
    check("to_clear", 32'({m0_ready, m0_error}), 32'b00);

    // both strobes low is a write
    m0_rd_n = 1'b0; m0_wr_n = 1'b0; m0_address = 16'h0042; m0_wdata = 16'hA5A5;
    mem_ready = 1'b1;
    tick();
    check("both_low_write", 32'({mem_rd_n, mem_wr_n}), 32'b10);
    m0_rd_n = 1'b1; m0_wr_n = 1'b1;
    tick();
    check("both_low_rdata", 32'(m0_rdata), 32'hFFFF);
    tick();
    mem_ready = 1'b0;

    // reset during ACCESS; afterwards m0 wins the first contention
    m1_rd_n = 1'b0; m1_address = 16'h0300;
    tick();
    check("ra_grant", 32'(grant), 32'h2);
    reset = 1'b0;
    tick();
    check("ra_strobes", 32'({mem_rd_n, mem_wr_n}), 32'b11);
    check("ra_grant_off", 32'(grant), 32'h0);
    check("ra_no_ready", 32'({m0_ready, m1_ready}), 32'b00);
    reset = 1'b1; m0_rd_n = 1'b0;
    tick();
    check("ra_first_win", 32'(grant), 32'h1);
    mem_ready = 1'b1;
    m0_rd_n = 1'b1; m1_rd_n = 1'b1;
    tick();
    check("ra_after_ready", 32'({m0_ready, m1_ready}), 32'b10);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tiny16_bus_arbiter.md
TINY16_BUS_ARBITER -- requirements
Module: tiny16_bus_arbiter

Interface
REQ-001 Parameter ROUND_ROBIN, default 1: 1 = alternate grants between requesters on contention; 0 = requester 0 always wins.
REQ-002 Parameter TIMEOUT, default 15: maximum memory cycles waited for mem_ready before abort, range 1..255.
REQ-003 clk  input  1  clock; all state changes on posedge clk.
REQ-004 reset  input  1  synchronous, active-low.
REQ-005 m0_rd_n, m0_wr_n  input  1 each  requester 0 (CPU) read/write strobes, active-low.
REQ-006 m0_address  input  16  requester 0 address.
REQ-007 m0_wdata  input  16  requester 0 write data.
REQ-008 m0_rdata  output  16  requester 0 read data, valid while m0_ready=1.
REQ-009 m0_ready  output  1  one-cycle completion pulse to requester 0.
REQ-010 m0_error  output  1  asserted with m0_ready when the access timed out.
REQ-011 m1_rd_n, m1_wr_n, m1_address, m1_wdata, m1_rdata, m1_ready, m1_error: same directions, widths and meanings for requester 1 (DMA).
REQ-012 mem_rd_n, mem_wr_n  output  1 each  shared memory strobes, active-low.
REQ-013 mem_address  output  16  shared memory address.
REQ-014 mem_wdata  output  16  shared memory write data.
REQ-015 mem_rdata  input  16  shared memory read data.
REQ-016 mem_ready  input  1  memory completion, sampled while a strobe is active.
REQ-017 grant  output  2  one-hot owner of current access (bit0 = m0, bit1 = m1); 0 when idle.

Function
REQ-018 Requester "requests" when rd_n=0 or wr_n=0; both low is a write.
REQ-019 FSM states IDLE, ACCESS, DONE. IDLE: no strobes, grant=0.
REQ-020 IDLE with >=1 request: register winner's address, wdata and direction; set grant; go to ACCESS next cycle.
REQ-021 Contention, ROUND_ROBIN=1: grant the requester not granted last; ROUND_ROBIN=0: grant m0.
REQ-022 ACCESS: exactly one of mem_rd_n/mem_wr_n low; address/wdata held from registered copy, stable until leaving ACCESS.
REQ-023 ACCESS with mem_ready=1: capture mem_rdata (reads), go to DONE; latency request-seen to ready pulse = 2 cycles with zero-wait memory.
REQ-024 Timeout counter clears on entering ACCESS, increments per ACCESS cycle with mem_ready=0; reaching TIMEOUT goes to DONE with error, rdata = 16'hFFFF.
REQ-025 DONE: strobes high, granted requester's ready=1 for exactly one cycle, error=1 only on timeout, other requester's ready/error=0; last-grant updated; next state IDLE.
REQ-026 No new grant in DONE; requesters must release strobes within the cycle after ready, else a new access is started.
REQ-027 Requester dropping its strobe during ACCESS does not abort; access completes and ready still pulses.
REQ-028 mX_rdata holds last captured value between accesses; wdata never forwarded to rdata.
REQ-029 mem_ready outside ACCESS ignored.

Reset
REQ-030 reset=0 at posedge: state IDLE, mem_rd_n=mem_wr_n=1, grant=0, ready/error=0, rdata=0, mem_address=0, mem_wdata=0, counter=0, last-grant=m1 (m0 wins first contention).
REQ-031 Reset mid-ACCESS drops strobes at that same edge; no ready pulse issued for the aborted access.

Verification
REQ-032 m0 read 0x0100, mem_ready tied 1, mem_rdata=0x1234 -> mem_rd_n low cycle 1, m0_ready=1 and m0_rdata=0x1234 cycle 2, grant=01 then 00.
REQ-033 m0 and m1 both request continuously, ROUND_ROBIN=1 -> grants m0,m1,m0,m1; with ROUND_ROBIN=0 -> m0 every time.
REQ-034 m1 write 0xBEEF to 0x8000, mem_ready low 3 cycles -> mem_wr_n low 4 cycles, address/wdata stable, m1_ready pulse once, m1_error=0.
REQ-035 m0 read, mem_ready never high, TIMEOUT=15 -> after 15 ACCESS cycles m0_ready=1, m0_error=1, m0_rdata=0xFFFF.
REQ-036 reset=0 asserted during ACCESS -> strobes high next edge, no ready, grant=0; after release m0 wins first contention.
